// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline memory stage.
// Holds the M-stage FSM encoding and the M->W register layout with its bubble value.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_REQ  = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            reg_write;
    logic            result_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '0;

endpackage

// File: rtl/mem_access_timer.sv
// Wait-state counter for an outstanding bus access; expired flags the last
// allowed REQ cycle so the abort can retire in that same cycle.
module mem_access_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count_q == CW'(LAST));

endmodule

// File: rtl/mux.sv
// Generic 2:1 multiplexer shared across the pipeline datapath.
module Mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: issues word loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, and owns the M->W pipeline register.
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            StallM,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            bus_err,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ResultW
);

  mem_state_e      state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic            bus_err_q, bus_err_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  w_reg_t          w_q, w_d;
  logic            mem_op, timer_expired, timeout, in_req;

  assign mem_op  = MemReadM | MemWriteM;
  assign in_req  = (state_q == MEM_ST_REQ);
  assign timeout = in_req && !bus_ack && timer_expired;

  mem_access_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_req),
    .en      (in_req && !bus_ack),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_ST_IDLE: if (mem_op)              state_d = MEM_ST_REQ;
      MEM_ST_REQ:  if (bus_ack || timeout)  state_d = MEM_ST_IDLE;
      default:                              state_d = MEM_ST_IDLE;
    endcase
  end

  always_comb begin
    StallM = 1'b0;
    case (state_q)
      MEM_ST_IDLE: StallM = mem_op;
      MEM_ST_REQ:  StallM = !bus_ack && !timeout;
      default:     StallM = 1'b0;
    endcase
  end

  // Bus outputs are held once issued; only req drops on ack or abort.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = bus_err_q | timeout;
    if (!in_req && mem_op) begin
      bus_req_d   = 1'b1;
      bus_we_d    = MemWriteM;
      bus_addr_d  = {ALU_ResultM[XLEN-1:2], 2'b00};
      bus_wdata_d = WriteDataM;
    end else if (in_req && (bus_ack || timeout)) begin
      bus_req_d = 1'b0;
    end
  end

  // The instruction retires exactly in the cycle the stall is released.
  always_comb begin
    w_d = W_BUBBLE;
    if (!StallM) begin
      w_d.reg_write  = RegWriteM;
      w_d.result_src = ResultSrcM;
      w_d.rd         = RD_M;
      w_d.alu_result = ALU_ResultM;
      w_d.pc_plus4   = PCPlus4M;
      w_d.read_data  = (in_req && bus_ack && MemReadM && !MemWriteM) ? bus_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      w_q         <= W_BUBBLE;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      w_q         <= w_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_err     = bus_err_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RD_W        = w_q.rd;
  assign ALU_ResultW = w_q.alu_result;
  assign ReadDataW   = w_q.read_data;
  assign PCPlus4W    = w_q.pc_plus4;

  Mux #(.WIDTH(XLEN)) u_result_mux (
    .d0 (w_q.alu_result),
    .d1 (w_q.read_data),
    .s  (w_q.result_src),
    .y  (ResultW)
  );

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: a transaction-level model
// predicts per-cycle stall, bus and W-register values for each instruction.
module tb_memory_access_stage;

  localparam int TO = 4;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3;

  typedef struct {
    int          kind;
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } instr_t;

  typedef struct packed {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } wexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RegWriteM = 0, MemReadM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0]  RD_M = '0;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic        StallM, bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected values for the current cycle, plus what the next edge must load.
  logic        check_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata;
  wexp_t       exp_w, pend_w;
  logic        pend_err;

  // Observation counters used by the hand-computed literal checks.
  int stall_seen = 0, req_high = 0, req_rises = 0, wr_seen = 0;
  logic prev_req = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("StallM", StallM, exp_stall);
      check("bus_req", bus_req, exp_req);
      check("bus_err", bus_err, exp_err);
      if (exp_req) begin
        check("bus_we", bus_we, exp_we);
        check("bus_addr", bus_addr, exp_addr);
        check("bus_wdata", bus_wdata, exp_wdata);
      end
      check("RegWriteW", RegWriteW, exp_w.rw);
      check("ResultSrcW", ResultSrcW, exp_w.rs);
      check("RD_W", RD_W, exp_w.rd);
      check("ALU_ResultW", ALU_ResultW, exp_w.alu);
      check("ReadDataW", ReadDataW, exp_w.rdata);
      check("PCPlus4W", PCPlus4W, exp_w.pc4);
      check("ResultW", ResultW, exp_w.rs ? exp_w.rdata : exp_w.alu);
      if (StallM === 1'b1) stall_seen++;
      if (RegWriteW === 1'b1) wr_seen++;
      if (bus_req === 1'b1) begin
        req_high++;
        if (!prev_req) req_rises++;
        last_addr = bus_addr;
        last_we = bus_we;
        last_wdata = bus_wdata;
      end
      prev_req = (bus_req === 1'b1);
    end
  end

  task automatic drive_cycle(input logic rst_v, input instr_t in, input logic ack,
                             input logic [31:0] rdata, input logic e_stall, input logic e_req,
                             input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                             input wexp_t nw, input logic nerr);
    @(posedge clk);
    #1;
    exp_w = pend_w;
    exp_err = pend_err;
    rst = rst_v;
    RegWriteM = in.rw;
    ResultSrcM = in.rs;
    RD_M = in.rd;
    ALU_ResultM = in.alu;
    WriteDataM = in.wd;
    PCPlus4M = in.pc4;
    MemReadM = (in.kind == K_LOAD) || (in.kind == K_BOTH);
    MemWriteM = (in.kind == K_STORE) || (in.kind == K_BOTH);
    bus_ack = ack;
    bus_rdata = rdata;
    exp_stall = e_stall;
    exp_req = e_req;
    exp_we = e_we;
    exp_addr = e_addr;
    exp_wdata = e_wdata;
    pend_w = nw;
    pend_err = nerr;
  endtask

  // One instruction through M. waits = wait states before ack; waits >= TO means no ack.
  task automatic exec_instr(input instr_t in, input int waits, input logic [31:0] rdata);
    wexp_t ret;
    logic is_wr, is_load, to, last, ack;
    int n_req;
    logic [31:0] addr;
    is_wr = (in.kind == K_STORE) || (in.kind == K_BOTH);
    is_load = (in.kind == K_LOAD);
    addr = in.alu & 32'hFFFF_FFFC;
    ret.rw = in.rw;
    ret.rs = in.rs;
    ret.rd = in.rd;
    ret.alu = in.alu;
    ret.pc4 = in.pc4;
    ret.rdata = '0;
    if (in.kind == K_ALU) begin
      drive_cycle(1'b0, in, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, '0, '0, ret, pend_err);
    end else begin
      drive_cycle(1'b0, in, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 1'b0, '0, '0, '0, pend_err);
      to = (waits >= TO);
      n_req = to ? TO : waits + 1;
      for (int r = 0; r < n_req; r++) begin
        last = (r == n_req - 1);
        ack = last && !to;
        ret.rdata = (ack && is_load) ? rdata : '0;
        drive_cycle(1'b0, in, ack, ack ? rdata : $urandom, !last, 1'b1, is_wr, addr, in.wd,
                    last ? ret : wexp_t'('0), pend_err | (last && to));
      end
    end
  endtask

  function automatic instr_t mk(input int kind, input logic rw, input logic rs, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4);
    instr_t i;
    i.kind = kind; i.rw = rw; i.rs = rs; i.rd = rd; i.alu = alu; i.wd = wd; i.pc4 = pc4;
    return i;
  endfunction

  instr_t nop;
  int s0, q0, r0, w0;

  initial begin
    nop = mk(K_ALU, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    repeat (2) @(posedge clk);
    pend_w = '0;
    pend_err = 1'b0;
    check_en = 1'b1;

    // Reset state.
    drive_cycle(1'b1, nop, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_we", bus_we, 1'b0);
    check("rst_resultw", ResultW, 32'h0);

    // ALU op: retires next cycle with no stall.
    s0 = stall_seen;
    exec_instr(mk(K_ALU, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h44), 0, '0);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("alu_rd_w", RD_W, 32'd5);
    check("alu_resultw", ResultW, 32'h1234);
    check("alu_no_stall", stall_seen - s0, 32'd0);

    // Load from 0x103 with two wait states.
    s0 = stall_seen;
    exec_instr(mk(K_LOAD, 1'b1, 1'b1, 5'd7, 32'h103, 32'h0, 32'h80), 2, 32'hDEADBEEF);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("ld_readdataw", ReadDataW, 32'hDEADBEEF);
    check("ld_resultw", ResultW, 32'hDEADBEEF);
    check("ld_regwritew", RegWriteW, 1'b1);
    check("ld_addr", last_addr, 32'h100);
    check("ld_we", last_we, 1'b0);
    check("ld_stall_cycles", stall_seen - s0, 32'd3);

    // Store of 0xA5A5A5A5 to 0x200, same-cycle ack.
    s0 = stall_seen;
    exec_instr(mk(K_STORE, 1'b0, 1'b0, 5'd0, 32'h200, 32'hA5A5A5A5, 32'h90), 0, '0);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("st_we", last_we, 1'b1);
    check("st_wdata", last_wdata, 32'hA5A5A5A5);
    check("st_addr", last_addr, 32'h200);
    check("st_regwritew", RegWriteW, 1'b0);
    check("st_stall_cycles", stall_seen - s0, 32'd1);

    // Back-to-back loads.
    r0 = req_rises;
    w0 = wr_seen;
    exec_instr(mk(K_LOAD, 1'b1, 1'b1, 5'd1, 32'h400, 32'h0, 32'hA0), 0, 32'h1111_0001);
    exec_instr(mk(K_LOAD, 1'b1, 1'b1, 5'd2, 32'h404, 32'h0, 32'hA4), 1, 32'h2222_0002);
    exec_instr(nop, 0, '0);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("b2b_req_pulses", req_rises - r0, 32'd2);
    check("b2b_w_writes", wr_seen - w0, 32'd2);

    // Timeout abort: no ack ever arrives.
    s0 = stall_seen;
    q0 = req_high;
    exec_instr(mk(K_LOAD, 1'b1, 1'b0, 5'd9, 32'h500, 32'h0, 32'hB0), 10, 32'hFFFF_FFFF);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("to_err", bus_err, 1'b1);
    check("to_readdataw", ReadDataW, 32'h0);
    check("to_req_cycles", req_high - q0, 32'd4);
    check("to_stall_cycles", stall_seen - s0, 32'd4);
    exec_instr(nop, 0, '0);
    @(negedge clk);
    check("to_err_sticky", bus_err, 1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      instr_t ri;
      ri = mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom), $urandom, $urandom, $urandom);
      exec_instr(ri, $urandom_range(0, 5), $urandom);
    end

    // Reset in mid-REQ followed by a late ack.
    begin
      instr_t ld;
      ld = mk(K_LOAD, 1'b1, 1'b1, 5'd3, 32'h300, 32'h0, 32'hC0);
      drive_cycle(1'b0, ld, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, '0, pend_err);
      drive_cycle(1'b0, ld, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, '0, pend_err);
      drive_cycle(1'b1, ld, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, '0, 1'b0);
      drive_cycle(1'b0, nop, 1'b1, 32'hBADBAD00, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      @(negedge clk);
      check("mrst_req", bus_req, 1'b0);
      check("mrst_err", bus_err, 1'b0);
      check("mrst_regwritew", RegWriteW, 1'b0);
      check("mrst_addr", bus_addr, 32'h0);
      exec_instr(nop, 0, '0);
      @(negedge clk);
      check("mrst_late_ack", RegWriteW, 1'b0);
      check("mrst_resultw", ResultW, 32'h0);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
